debug_unit: RTL and testbench

Host-side controller for the MIPS pipeline. It receives command bytes from a UART receiver and writes program words into the IF instruction memory through the write/instruction/address loader interface. It also gates the pipeline enable for single-step and free-run execution. For dumps, it drives the register-file debug read address, collects PC and register contents, and serialises them to a UART transmitter.

---
 rtl/debug_unit.sv | 155 +++++++++++++++
 tb/tb_debug_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_unit.sv
// Host-side debug controller: loads program words from UART, gates pipeline
// stepping/running, and streams PC plus register-file contents back over UART.
module debug_unit #(
  parameter int NB_ADDR = 32,
  parameter int NB_INST = 32,
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_BYTE = 8,
  parameter int N_REGS  = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_write,
  output logic [NB_INST-1:0] o_instruction,
  output logic [NB_ADDR-1:0] o_address,
  output logic               o_enable,
  output logic [NB_REG-1:0]  o_address_read_debug,
  input  logic [NB_DATA-1:0] i_data_read_debug,
  input  logic [NB_ADDR-1:0] i_pc,
  output logic               o_busy
);

  localparam logic [NB_BYTE-1:0] CMD_LOAD = 8'h4C;
  localparam logic [NB_BYTE-1:0] CMD_STEP = 8'h53;
  localparam logic [NB_BYTE-1:0] CMD_RUN  = 8'h52;
  localparam logic [NB_BYTE-1:0] CMD_DUMP = 8'h44;
  localparam logic [NB_BYTE-1:0] CMD_HALT = 8'h48;
  localparam logic [NB_BYTE-1:0] ONE_B    = 1;
  localparam logic [NB_REG-1:0]  LAST_REG = NB_REG'(N_REGS - 1);

  typedef enum logic [3:0] {
    IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WRITE, STEP, RUN,
    DUMP_ADDR, DUMP_LATCH, DUMP_SEND
  } state_t;

  state_t state, next_state;

  logic [NB_BYTE-1:0]         word_cnt;
  logic [NB_BYTE-1:0]         word_idx;
  logic [1:0]                 byte_cnt;
  logic [NB_INST-NB_BYTE-1:0] shift_reg;
  logic [NB_DATA-1:0]         tx_word;
  logic [NB_REG-1:0]          reg_idx;
  logic                       pc_phase;
  logic                       handshake;
  logic                       word_sent;

  assign handshake = (state == DUMP_SEND) && i_tx_ready;
  assign word_sent = handshake && (byte_cnt == 2'd3);

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: next_state = LOAD_CNT;
            CMD_STEP: next_state = STEP;
            CMD_RUN:  next_state = RUN;
            CMD_DUMP: next_state = DUMP_ADDR;
            default:  next_state = IDLE;
          endcase
        end
      end
      LOAD_CNT:   if (i_rx_valid) next_state = (i_rx_data == '0) ? IDLE : LOAD_BYTE;
      LOAD_BYTE:  if (i_rx_valid && byte_cnt == 2'd3) next_state = LOAD_WRITE;
      LOAD_WRITE: next_state = ((word_idx + ONE_B) == word_cnt) ? IDLE : LOAD_BYTE;
      STEP:       next_state = IDLE;
      RUN:        if (i_rx_valid && i_rx_data == CMD_HALT) next_state = IDLE;
      DUMP_ADDR:  next_state = DUMP_LATCH;
      DUMP_LATCH: next_state = DUMP_SEND;
      DUMP_SEND:  if (word_sent) next_state = (pc_phase || reg_idx != LAST_REG) ? DUMP_ADDR : IDLE;
      default:    next_state = IDLE;
    endcase
  end

  // The PC word goes out first; it is captured on the 'D' command and the
  // latch state leaves it untouched while pc_phase is set.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      word_cnt      <= '0;
      word_idx      <= '0;
      byte_cnt      <= '0;
      shift_reg     <= '0;
      tx_word       <= '0;
      reg_idx       <= '0;
      pc_phase      <= 1'b0;
      o_instruction <= '0;
      o_address     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_rx_valid && i_rx_data == CMD_DUMP) begin
            tx_word  <= NB_DATA'(i_pc);
            pc_phase <= 1'b1;
            reg_idx  <= '0;
            byte_cnt <= '0;
          end
        end
        LOAD_CNT: begin
          if (i_rx_valid) begin
            word_cnt <= i_rx_data;
            word_idx <= '0;
            byte_cnt <= '0;
          end
        end
        LOAD_BYTE: begin
          if (i_rx_valid) begin
            shift_reg <= {shift_reg[NB_INST-2*NB_BYTE-1:0], i_rx_data};
            byte_cnt  <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              o_instruction <= {shift_reg, i_rx_data};
              o_address     <= NB_ADDR'({word_idx, 2'b00});
            end
          end
        end
        LOAD_WRITE: word_idx <= word_idx + ONE_B;
        DUMP_LATCH: if (!pc_phase) tx_word <= i_data_read_debug;
        DUMP_SEND: begin
          if (handshake) begin
            tx_word  <= tx_word << NB_BYTE;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (pc_phase)               pc_phase <= 1'b0;
              else if (reg_idx == LAST_REG) reg_idx <= '0;
              else                        reg_idx  <= reg_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_write    = (state == LOAD_WRITE);
    o_enable   = (state == STEP) || (state == RUN);
    o_tx_valid = (state == DUMP_SEND);
    o_tx_data  = o_tx_valid ? tx_word[NB_DATA-1 -: NB_BYTE] : '0;
    o_busy     = (state != IDLE);
  end

  assign o_address_read_debug = reg_idx;

endmodule

// File: tb/tb_debug_unit.sv
// Directed bench for debug_unit: a transaction-level model (expected write and
// byte queues) checked every cycle, plus literal spot checks.
module tb_debug_unit;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [7:0]  i_rx_data = '0;
  logic        i_rx_valid = 1'b0;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready = 1'b1;
  logic        o_write;
  logic [31:0] o_instruction;
  logic [31:0] o_address;
  logic        o_enable;
  logic [4:0]  o_address_read_debug;
  logic [31:0] i_data_read_debug;
  logic [31:0] i_pc = '0;
  logic        o_busy;

  logic [31:0] regs [32];

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [7:0] data; int ridx; } tx_t;
  wr_t        exp_wr[$];
  tx_t        exp_tx[$];
  logic [7:0] tx_log[$];

  int   n_checks = 0;
  int   n_pass = 0;
  int   enable_cycles = 0;
  int   write_count = 0;
  bit   ready_toggle = 1'b0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  debug_unit dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_write(o_write), .o_instruction(o_instruction), .o_address(o_address),
    .o_enable(o_enable), .o_address_read_debug(o_address_read_debug),
    .i_data_read_debug(i_data_read_debug), .i_pc(i_pc), .o_busy(o_busy)
  );

  initial forever #5 i_clk = ~i_clk;

  assign i_data_read_debug = regs[o_address_read_debug];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(posedge i_clk); #2;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(posedge i_clk); #2;
    i_rx_valid = 1'b0;
  endtask

  task automatic doReset();
    @(posedge i_clk); #2 i_reset = 1'b1;
    @(posedge i_clk); @(posedge i_clk); #2 i_reset = 1'b0;
  endtask

  task automatic waitIdle(input int limit, input string name);
    for (int i = 0; i < limit; i++) begin
      @(negedge i_clk);
      if (!o_busy) break;
    end
    checkOutput(name, {31'b0, o_busy}, 32'd0);
  endtask

  task automatic expectDump(input logic [31:0] pc);
    for (int b = 3; b >= 0; b--) exp_tx.push_back('{pc[b*8 +: 8], -1});
    for (int k = 0; k < 32; k++)
      for (int b = 3; b >= 0; b--) exp_tx.push_back('{regs[k][b*8 +: 8], k});
  endtask

  // Transmitter readiness: always ready, or alternating 3 cycles on / 3 off.
  initial begin
    int rcnt = 0;
    forever begin
      @(posedge i_clk); #2;
      if (ready_toggle) begin
        rcnt++;
        if (rcnt == 3) begin
          i_tx_ready = ~i_tx_ready;
          rcnt = 0;
        end
      end else begin
        i_tx_ready = 1'b1;
        rcnt = 0;
      end
    end
  end

  // Per-cycle comparison of the DUT's observable transactions to the model queues.
  initial begin
    wr_t w;
    tx_t t;
    forever begin
      @(negedge i_clk);
      if (o_enable) enable_cycles++;
      if (o_write || o_enable) checkOutput("write_enable_excl", {31'b0, o_write & o_enable}, 32'd0);
      if (o_write) begin
        write_count++;
        if (exp_wr.size() == 0) checkOutput("unexpected_write", exp_wr.size(), 32'd1);
        else begin
          w = exp_wr.pop_front();
          checkOutput("write_addr", o_address, w.addr);
          checkOutput("write_data", o_instruction, w.data);
        end
      end
      if (o_tx_valid && prev_stall) checkOutput("tx_stable", {24'b0, o_tx_data}, {24'b0, prev_data});
      if (o_tx_valid && i_tx_ready) begin
        tx_log.push_back(o_tx_data);
        if (exp_tx.size() == 0) checkOutput("unexpected_tx", exp_tx.size(), 32'd1);
        else begin
          t = exp_tx.pop_front();
          checkOutput("tx_byte", {24'b0, o_tx_data}, {24'b0, t.data});
          if (t.ridx >= 0) checkOutput("dbg_addr", {27'b0, o_address_read_debug}, t.ridx);
        end
      end
      prev_stall = o_tx_valid && !i_tx_ready;
      prev_data  = o_tx_data;
    end
  end

  initial begin
    for (int k = 0; k < 32; k++) regs[k] = k * 32'h11111111;
    doReset();
    @(negedge i_clk);
    checkOutput("rst_busy", {31'b0, o_busy}, 32'd0);
    checkOutput("rst_write", {31'b0, o_write}, 32'd0);
    checkOutput("rst_enable", {31'b0, o_enable}, 32'd0);
    checkOutput("rst_tx_valid", {31'b0, o_tx_valid}, 32'd0);
    checkOutput("rst_tx_data", {24'b0, o_tx_data}, 32'd0);
    checkOutput("rst_addr", o_address, 32'd0);
    checkOutput("rst_instr", o_instruction, 32'd0);
    checkOutput("rst_dbg_addr", {27'b0, o_address_read_debug}, 32'd0);

    applyStimulus(8'h41);
    @(negedge i_clk);
    checkOutput("ignore_cmd_busy", {31'b0, o_busy}, 32'd0);

    // Two-word program load
    write_count = 0;
    exp_wr.push_back('{32'h0, 32'h20010005});
    exp_wr.push_back('{32'h4, 32'h00221820});
    applyStimulus(8'h4C); applyStimulus(8'h02);
    applyStimulus(8'h20); applyStimulus(8'h01); applyStimulus(8'h00); applyStimulus(8'h05);
    applyStimulus(8'h00); applyStimulus(8'h22); applyStimulus(8'h18); applyStimulus(8'h20);
    waitIdle(20, "load_idle");
    checkOutput("load_writes", write_count, 32'd2);
    checkOutput("load_queue_empty", exp_wr.size(), 32'd0);
    checkOutput("load_instr_held", o_instruction, 32'h00221820);
    checkOutput("load_addr_held", o_address, 32'h4);

    // Zero-length load
    write_count = 0;
    applyStimulus(8'h4C); applyStimulus(8'h00);
    @(negedge i_clk);
    checkOutput("load0_idle", {31'b0, o_busy}, 32'd0);
    repeat (3) @(negedge i_clk);
    checkOutput("load0_writes", write_count, 32'd0);

    // Single step
    enable_cycles = 0;
    applyStimulus(8'h53);
    repeat (3) @(negedge i_clk);
    checkOutput("step_cycles", enable_cycles, 32'd1);

    // Free run, ignored byte, halt
    enable_cycles = 0;
    applyStimulus(8'h52);
    repeat (10) @(posedge i_clk);
    applyStimulus(8'h41);
    @(negedge i_clk);
    checkOutput("run_enable", {31'b0, o_enable}, 32'd1);
    applyStimulus(8'h48);
    @(negedge i_clk);
    checkOutput("halt_enable", {31'b0, o_enable}, 32'd0);
    checkOutput("run_cycles", enable_cycles, 32'd14);

    // Dump with transmitter always ready
    tx_log.delete();
    i_pc = 32'h00000010;
    expectDump(i_pc);
    applyStimulus(8'h44);
    waitIdle(1000, "dump_idle");
    checkOutput("dump_count", tx_log.size(), 32'd132);
    checkOutput("dump_queue_empty", exp_tx.size(), 32'd0);
    checkOutput("dump_dbg_addr_end", {27'b0, o_address_read_debug}, 32'd0);
    if (tx_log.size() == 132) begin
      checkOutput("dump_byte3", {24'b0, tx_log[3]}, 32'h10);
      checkOutput("dump_byte8", {24'b0, tx_log[8]}, 32'h11);
      checkOutput("dump_byte131", {24'b0, tx_log[131]}, 32'h0F);
    end

    // Dump with back-pressure
    tx_log.delete();
    i_pc = 32'h00000ABC;
    expectDump(i_pc);
    ready_toggle = 1'b1;
    applyStimulus(8'h44);
    waitIdle(3000, "dump_bp_idle");
    ready_toggle = 1'b0;
    checkOutput("dump_bp_count", tx_log.size(), 32'd132);
    checkOutput("dump_bp_queue_empty", exp_tx.size(), 32'd0);

    // Reset in the middle of a load word discards the partial word
    applyStimulus(8'h4C); applyStimulus(8'h01); applyStimulus(8'hAA); applyStimulus(8'hBB);
    doReset();
    write_count = 0;
    exp_wr.push_back('{32'h0, 32'hCAFEF00D});
    applyStimulus(8'h4C); applyStimulus(8'h01);
    applyStimulus(8'hCA); applyStimulus(8'hFE); applyStimulus(8'hF0); applyStimulus(8'h0D);
    waitIdle(20, "reload_idle");
    checkOutput("reload_writes", write_count, 32'd1);
    checkOutput("reload_queue_empty", exp_wr.size(), 32'd0);

    // Reset during RUN
    applyStimulus(8'h52);
    repeat (3) @(negedge i_clk);
    checkOutput("run2_enable", {31'b0, o_enable}, 32'd1);
    @(posedge i_clk); #2 i_reset = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("run_reset_enable", {31'b0, o_enable}, 32'd0);
    checkOutput("run_reset_busy", {31'b0, o_busy}, 32'd0);
    @(posedge i_clk); #2 i_reset = 1'b0;
    repeat (2) @(negedge i_clk);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
